muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 50 +++++
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the iterative multiply/divide unit.
//   - op encodings driven on muldiv_unit.op
//   - FSM state encoding (also visible on muldiv_unit.dbg_state)
//   - datapath width and iteration count
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;

    // The counter is 6 bits wide. The last iteration is the one where it reads ITER-1.
    localparam logic [5:0] LAST_ITER = 6'd31;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MUL  = 2'b01;
    localparam logic [1:0] ST_DIV  = 2'b10;
    localparam logic [1:0] ST_FIX  = 2'b11;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
// Optional feature macro: MULDIV_DIV_EN builds the restoring-subtract path.
// Without it, only the shift-add path exists and div_mode_i is ignored.
//
// Ports:
//   acc_i      in  64  current accumulator
//                      multiply: {partial product, remaining multiplier bits}
//                      divide:   {partial remainder, dividend/quotient bits}
//   opnd_i     in  32  multiplicand (multiply) or divisor (divide) magnitude
//   div_mode_i in  1   0 selects a shift-add step, 1 selects a restoring-subtract step
//   acc_o      out 64  accumulator after one step
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               div_mode_i,
    output logic [2*WIDTH-1:0] acc_o
);

    // Shift-add step. The add takes the multiplicand when the low multiplier bit is 1.
    // The carry out of the add becomes the new top bit after the right shift.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} +
                      (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_i[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    // Restoring step. Shift {rem,quot} left by one, then try to subtract the divisor.
    // The partial remainder stays below twice the divisor.
    // So bit WIDTH of the difference is set exactly when the subtract would go negative.
    logic [WIDTH:0]     div_rem;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    assign div_rem  = acc_i[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_rem - {1'b0, opnd_i};
    assign div_next = div_diff[WIDTH] ? {acc_i[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};

    assign acc_o = div_mode_i ? div_next : mul_next;
`else
    logic unused_div_mode;
    assign unused_div_mode = div_mode_i;
    assign acc_o           = mul_next;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
// A launched operation runs 32 iterations in MUL or DIV.
// It then takes one FIX cycle to apply the result signs and write HI/LO.
// Optional feature macro: MULDIV_DIV_EN.
//   Defined:   DIV/DIVU are built.
//   Undefined: a start with op[1]=1 is ignored.
//
// Ports:
//   clk        in  1      core clock
//   reset      in  1      synchronous active-high reset
//   start      in  1      launch op (IDLE only)
//   op         in  2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data    in  WIDTH  operand A (multiplicand / dividend)
//   rt_data    in  WIDTH  operand B (multiplier / divisor)
//   hi_we      in  1      MTHI write (IDLE and start=0 only)
//   lo_we      in  1      MTLO write (IDLE and start=0 only)
//   wdata      in  WIDTH  MTHI/MTLO data
//   busy       out 1      operation in flight
//   done       out 1      one-cycle pulse after HI/LO take a result
//   hi         out WIDTH  HI register
//   lo         out WIDTH  LO register
//   dbg_state  out 2      current FSM state (muldiv_pkg ST_* encoding)
module muldiv_unit #(
    parameter int WIDTH = muldiv_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);
    import muldiv_pkg::*;

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   rs_raw_q, rs_raw_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [2*WIDTH-1:0] step_acc;

    // Launch-time operand conditioning. Only MULT/DIV (op[0]=0) are signed.
    logic             is_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             launch_ok;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & rs_data[WIDTH-1];
    assign b_neg     = is_signed & rt_data[WIDTH-1];
    assign a_mag     = a_neg ? -rs_data : rs_data;
    assign b_mag     = b_neg ? -rt_data : rt_data;

`ifdef MULDIV_DIV_EN
    assign launch_ok = 1'b1;
`else
    assign launch_ok = ~op[1];
`endif

    muldiv_step u_step (
        .acc_i      (acc_q),
        .opnd_i     (opnd_q),
        .div_mode_i (op_q[1]),
        .acc_o      (step_acc)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        rs_raw_d   = rs_raw_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A raised start always drops a same-cycle MTHI/MTLO.
                    // This holds even when a divide launch is not built.
                    if (launch_ok) begin
                        op_d       = op;
                        cnt_d      = 6'd0;
                        // Multiply: the multiplier sits in the low half and the multiplicand is the step operand.
                        // Divide: the dividend sits in the low half and the divisor is the step operand.
                        acc_d      = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        opnd_d     = op[1] ? b_mag : a_mag;
                        rs_raw_d   = rs_data;
                        neg_res_d  = a_neg ^ b_neg;
                        neg_rem_d  = a_neg;
                        div_zero_d = (rt_data == {WIDTH{1'b0}});
                        state_d    = op[1] ? ST_DIV : ST_MUL;
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            ST_MUL: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) state_d = ST_FIX;
            end
`ifdef MULDIV_DIV_EN
            ST_DIV: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) state_d = ST_FIX;
            end
`endif
            ST_FIX: begin
                if (!op_q[1]) begin
                    {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                end else if (div_zero_q) begin
                    lo_d = {WIDTH{1'b1}};
                    hi_d = rs_raw_q;
                end else begin
                    lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= 2'b00;
            cnt_q      <= 6'd0;
            acc_q      <= '0;
            opnd_q     <= '0;
            rs_raw_q   <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            rs_raw_q   <= rs_raw_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit.
// Inputs are driven 1 time unit after each rising edge.
// Outputs are sampled at that same point.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data, wdata;
    logic        hi_we, lo_we;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: launch one operation and scramble the operands afterwards.
    // It then waits (bounded) for done and reports the latency in edges after the start edge.
    // It also reports whether hi/lo moved or busy dropped before done.
    // With inject set, a second start and an MTHI/MTLO are raised mid-operation.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, output int lat, output bit moved, output bit busy_gap);
        logic [31:0] hi0, lo0;
        hi0 = hi; lo0 = lo;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        tick();
        start = 1'b0; rs_data = $urandom; rt_data = $urandom;
        lat = 0; moved = 1'b0; busy_gap = !busy;
        while (lat < 40) begin
            if (inject && lat == 5) begin
                start = 1'b1; op = OP_MULTU; rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            tick();
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            lat++;
            if (done) break;
            if (!busy) busy_gap = 1'b1;
            if (hi !== hi0 || lo !== lo0) moved = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (dbg_state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", dbg_state); end
    endtask

    task automatic test_mult();
        logic [1:0]  ops [4]  = '{OP_MULT, OP_MULT, OP_MULT, OP_MULTU};
        logic [31:0] av  [4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFA, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bv  [4]  = '{32'd5, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] eh  [4]  = '{32'hFFFF_FFFF, 32'h0, 32'h4000_0000, 32'hFFFF_FFFE};
        logic [31:0] el  [4]  = '{32'hFFFF_FFF1, 32'd42, 32'h0, 32'h0000_0001};
        int lat; bit moved, gap;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], av[i], bv[i], 1'b0, lat, moved, gap);
            checks++; if (lat !== 33) begin failures++; $display("FAIL mul%0d_latency got=%0d exp=33", i, lat); end
            checks++; if (moved || gap) begin failures++; $display("FAIL mul%0d_inflight got moved=%b gap=%b exp 0/0", i, moved, gap); end
            checks++; if (hi !== eh[i]) begin failures++; $display("FAIL mul%0d_hi got=%h exp=%h", i, hi, eh[i]); end
            checks++; if (lo !== el[i]) begin failures++; $display("FAIL mul%0d_lo got=%h exp=%h", i, lo, el[i]); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mul%0d_busy_at_done got=%b exp=0", i, busy); end
            tick();
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL mul%0d_done_pulse got=%b exp=0", i, done); end
        end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div();
        logic [1:0]  ops [5] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU};
        logic [31:0] av  [5] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7, 32'hFFFF_FFFF};
        logic [31:0] bv  [5] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd10};
        logic [31:0] eh  [5] = '{32'hFFFF_FFFF, 32'h0000_0064, 32'h0, 32'd1, 32'd5};
        logic [31:0] el  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD, 32'h1999_9999};
        int lat; bit moved, gap;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], av[i], bv[i], 1'b0, lat, moved, gap);
            checks++; if (lat !== 33) begin failures++; $display("FAIL div%0d_latency got=%0d exp=33", i, lat); end
            checks++; if (moved || gap) begin failures++; $display("FAIL div%0d_inflight got moved=%b gap=%b exp 0/0", i, moved, gap); end
            checks++; if (hi !== eh[i]) begin failures++; $display("FAIL div%0d_hi got=%h exp=%h", i, hi, eh[i]); end
            checks++; if (lo !== el[i]) begin failures++; $display("FAIL div%0d_lo got=%h exp=%h", i, lo, el[i]); end
        end
        tick();
    endtask
`else
    task automatic test_div();
        logic [31:0] hi0, lo0;
        bit saw_busy, saw_done;
        hi0 = hi; lo0 = lo; saw_busy = 1'b0; saw_done = 1'b0;
        start = 1'b1; op = OP_DIV; rs_data = 32'hFFFF_FFF9; rt_data = 32'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) saw_busy = 1'b1;
            if (done) saw_done = 1'b1;
            tick();
        end
        checks++; if (saw_busy) begin failures++; $display("FAIL div_off_busy got=1 exp=0"); end
        checks++; if (saw_done) begin failures++; $display("FAIL div_off_done got=1 exp=0"); end
        checks++; if (hi !== hi0) begin failures++; $display("FAIL div_off_hi got=%h exp=%h", hi, hi0); end
        checks++; if (lo !== lo0) begin failures++; $display("FAIL div_off_lo got=%h exp=%h", lo, lo0); end
    endtask
`endif

    task automatic test_mthi_busy();
        int lat; bit moved, gap;
        hi_we = 1'b1; wdata = 32'h0000_1234;
        tick();
        hi_we = 1'b0;
        checks++; if (hi !== 32'h0000_1234) begin failures++; $display("FAIL mthi got=%h exp=00001234", hi); end
        lo_we = 1'b1; wdata = 32'h0000_5678;
        tick();
        lo_we = 1'b0;
        checks++; if (lo !== 32'h0000_5678) begin failures++; $display("FAIL mtlo got=%h exp=00005678", lo); end
        checks++; if (hi !== 32'h0000_1234) begin failures++; $display("FAIL mtlo_hi_kept got=%h exp=00001234", hi); end
        do_op(OP_MULT, 32'd3, 32'd4, 1'b1, lat, moved, gap);
        checks++; if (lat !== 33) begin failures++; $display("FAIL busy_ign_latency got=%0d exp=33", lat); end
        checks++; if (moved) begin failures++; $display("FAIL busy_ign_hilo_moved got=1 exp=0"); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL busy_ign_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd12) begin failures++; $display("FAIL busy_ign_lo got=%h exp=0000000c", lo); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_ign_restart got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat; bit moved, gap;
        do_op(OP_MULT, 32'd2, 32'd3, 1'b0, lat, moved, gap);
        checks++; if (lo !== 32'd6) begin failures++; $display("FAIL b2b_first_lo got=%h exp=6", lo); end
        do_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0, lat, moved, gap);
        checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
        checks++; if (hi !== 32'd1 || lo !== 32'd0) begin failures++; $display("FAIL b2b_result got=%h_%h exp=00000001_00000000", hi, lo); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat; bit moved, gap;
        start = 1'b1; op = OP_MULT; rs_data = 32'd123; rt_data = 32'd456;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL rst_mid_hilo got=%h_%h exp=0_0", hi, lo); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%b exp=0", done); end
        do_op(OP_MULT, 32'd6, 32'd7, 1'b0, lat, moved, gap);
        checks++; if (lat !== 33) begin failures++; $display("FAIL rst_mid_latency got=%0d exp=33", lat); end
        checks++; if (hi !== 32'h0 || lo !== 32'd42) begin failures++; $display("FAIL rst_mid_result got=%h_%h exp=00000000_0000002a", hi, lo); end
        tick();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_busy();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
